// File: rtl/mem_bridge_pkg.sv
// Shared encodings and widths for the MainMemory3232 bridge sequencer.
package mem_bridge_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 8;
    localparam int RAM_SEL_BIT = 15;

    // Sequencer states, kept as plain constants so older tools read them too.
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_ACC    = 3'd1;
    localparam logic [2:0] RD_TURN   = 3'd2;
    localparam logic [2:0] WR_SETUP  = 3'd3;
    localparam logic [2:0] WR_STROBE = 3'd4;
    localparam logic [2:0] WR_HOLD   = 3'd5;
    localparam logic [2:0] ERR       = 3'd6;

    // Request fields captured at acceptance.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } memReq_t;

    // High address bit selects the RAM half; the low half is ROM.
    function automatic logic isRamAddr(input logic [ADDR_W-1:0] a);
        return a[RAM_SEL_BIT];
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module mem_wait_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Load on request, otherwise count down and park at zero (no wrap).
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= loadVal;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == '0);

endmodule

// File: rtl/mem_bridge_sequencer.sv
// Byte load/store sequencer driving the MainMemory3232 ROM/RAM bus.
// Reads hold Direction high for RD_WAIT cycles then turn the bus around;
// RAM writes go setup / strobe (WR_PULSE) / hold; ROM writes are rejected.
module mem_bridge_sequencer
    import mem_bridge_pkg::*;
#(
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_Write,
    input  logic [ADDR_W-1:0] Req_Addr,
    input  logic [DATA_W-1:0] Req_WData,
    output logic              Rsp_Valid,
    output logic [DATA_W-1:0] Rsp_RData,
    output logic              Rsp_Err,
    output logic [ADDR_W-1:0] Addr,
    inout  wire  [DATA_W-1:0] MEMDATA,
    output logic              MemBridge_Load,
    output logic              MemBridge_Direction
);

    localparam int MAX_WAIT = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
    localparam int CNT_W    = $clog2(MAX_WAIT) + 1;

    logic [2:0]       state;
    memReq_t          req;
    logic             timerLoad;
    logic [CNT_W-1:0] timerVal;
    logic             timerDone;
    logic             busDrive;
    logic             accept;

    assign Req_Ready = (state == IDLE);
    assign accept    = Req_Valid && Req_Ready;

    // Arm the timer on entry to RD_ACC (from IDLE) and WR_STROBE (from WR_SETUP).
    always_comb begin
        timerLoad = 1'b0;
        timerVal  = '0;
        if (accept && !Req_Write) begin
            timerLoad = 1'b1;
            timerVal  = CNT_W'(RD_WAIT - 1);
        end else if (state == WR_SETUP) begin
            timerLoad = 1'b1;
            timerVal  = CNT_W'(WR_PULSE - 1);
        end
    end

    mem_wait_timer #(.CNT_W(CNT_W)) uWaitTimer (
        .clk     (CLK),
        .rst     (RST),
        .load    (timerLoad),
        .loadVal (timerVal),
        .done    (timerDone)
    );

    // Main sequencer: latch request, step states, produce one-cycle responses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            req       <= '0;
            Rsp_Valid <= 1'b0;
            Rsp_Err   <= 1'b0;
            Rsp_RData <= '0;
        end else begin
            Rsp_Valid <= 1'b0;
            Rsp_Err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req <= '{write: Req_Write, addr: Req_Addr, wdata: Req_WData};
                        if (!Req_Write)
                            state <= RD_ACC;
                        else if (isRamAddr(Req_Addr))
                            state <= WR_SETUP;
                        else
                            state <= ERR;
                    end
                end
                RD_ACC: begin
                    if (timerDone) begin
                        Rsp_RData <= MEMDATA;
                        state     <= RD_TURN;
                    end
                end
                RD_TURN: begin
                    state     <= IDLE;
                    Rsp_Valid <= 1'b1;
                end
                WR_SETUP: begin
                    // Only writes ever land here; anything else is dropped safely.
                    state <= req.write ? WR_STROBE : IDLE;
                end
                WR_STROBE: begin
                    if (timerDone)
                        state <= WR_HOLD;
                end
                WR_HOLD: begin
                    state     <= IDLE;
                    Rsp_Valid <= 1'b1;
                end
                ERR: begin
                    state     <= IDLE;
                    Rsp_Valid <= 1'b1;
                    Rsp_Err   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus controls decode straight from state: drive and Direction are disjoint.
    assign busDrive            = (state == WR_SETUP) || (state == WR_STROBE) || (state == WR_HOLD);
    assign MemBridge_Direction = (state == RD_ACC);
    assign MemBridge_Load      = (state != WR_STROBE);
    assign Addr                = req.addr;
    assign MEMDATA             = busDrive ? req.wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bridge_sequencer.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor
// pops and compares on every Rsp_Valid and watches the bus protocol.
module tb_mem_bridge_sequencer;

    localparam int RD_WAIT  = 2;
    localparam int WR_PULSE = 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Req_Valid = 1'b0;
    logic        Req_Write = 1'b0;
    logic [15:0] Req_Addr  = '0;
    logic [7:0]  Req_WData = '0;
    logic        Req_Ready, Rsp_Valid, Rsp_Err, MemBridge_Load, MemBridge_Direction;
    logic [7:0]  Rsp_RData;
    logic [15:0] Addr;
    wire  [7:0]  MEMDATA;

    mem_bridge_sequencer #(.RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE)) dut (
        .CLK(CLK), .RST(RST),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
        .Req_Addr(Req_Addr), .Req_WData(Req_WData),
        .Rsp_Valid(Rsp_Valid), .Rsp_RData(Rsp_RData), .Rsp_Err(Rsp_Err),
        .Addr(Addr), .MEMDATA(MEMDATA),
        .MemBridge_Load(MemBridge_Load), .MemBridge_Direction(MemBridge_Direction)
    );

    // Memory model: ROM image in the low half, RAM written on Load low.
    logic [7:0] mem [0:65535];
    logic [7:0] memRd;
    assign memRd   = mem[Addr];
    assign MEMDATA = MemBridge_Direction ? memRd : 8'hzz;

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!RST && !MemBridge_Load && Addr[15])
            mem[Addr] <= MEMDATA;
    end

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         acc;
        int         lat;
    } exp_t;
    exp_t sbq[$];

    int         checks = 0;
    int         errors = 0;
    int         rspCount = 0;
    logic [7:0] lastRd = 8'h00;
    logic [7:0] curWData = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response and bus-protocol monitor.
    logic prevRsp = 1'b0;
    int   dirRun = 0;
    int   loadRun = 0;
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            prevRsp = 1'b0;
            dirRun  = 0;
            loadRun = 0;
        end else begin
            if (Rsp_Valid) begin
                rspCount++;
                check("rsp_not_back_to_back", int'(prevRsp), 0);
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("rsp_rdata", int'(Rsp_RData), int'(e.rdata));
                    check("rsp_err", int'(Rsp_Err), int'(e.err));
                    check("rsp_latency", cyc - e.acc - 1, e.lat);
                end
            end
            prevRsp = Rsp_Valid;
            if (MemBridge_Direction) begin
                dirRun++;
                check("dir_load_overlap", int'(MemBridge_Load), 1);
                check("rd_bus_value", int'(MEMDATA), int'(memRd));
            end else if (dirRun != 0) begin
                check("dir_width", dirRun, RD_WAIT);
                dirRun = 0;
            end
            if (!MemBridge_Load) begin
                loadRun++;
                check("strobe_data", int'(MEMDATA), int'(curWData));
                check("strobe_ram_half", int'(Addr[15]), 1);
            end else if (loadRun != 0) begin
                check("load_width", loadRun, WR_PULSE);
                check("hold_data", int'(MEMDATA), int'(curWData));
                loadRun = 0;
            end
        end
    end

    // Present one request, wait for acceptance, queue its expected response.
    task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] expRd, input bit expectRsp);
        exp_t e;
        int   n = 0;
        @(negedge CLK);
        Req_Valid = 1'b1;
        Req_Write = wr;
        Req_Addr  = a;
        Req_WData = d;
        while (!Req_Ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("accept_wait", int'(Req_Ready), 1);
        if (wr) curWData = d;
        else    lastRd   = expRd;
        e.rdata = lastRd;
        e.err   = wr && !a[15];
        e.acc   = cyc;
        e.lat   = !wr ? RD_WAIT + 1 : (a[15] ? WR_PULSE + 2 : 1);
        if (expectRsp) sbq.push_back(e);
        @(posedge CLK);
        if (wr && a[15]) begin
            @(negedge CLK);
            check("setup_data", int'(MEMDATA), int'(d));
            check("setup_load_high", int'(MemBridge_Load), 1);
        end
    endtask

    task automatic idleReq();
        @(negedge CLK);
        Req_Valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("drain_queue", sbq.size(), 0);
        repeat (3) @(negedge CLK);
    endtask

    logic [7:0] rnd [0:4];
    int         rsp0;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0003] = 8'hA5;
        mem[16'h0010] = 8'h3C;

        // Reset state.
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_load", int'(MemBridge_Load), 1);
        check("rst_dir", int'(MemBridge_Direction), 0);
        check("rst_ready", int'(Req_Ready), 1);
        check("rst_rsp_valid", int'(Rsp_Valid), 0);
        check("rst_addr", int'(Addr), 0);
        check("rst_rdata", int'(Rsp_RData), 0);
        RST = 1'b0;

        // ROM read.
        issue(1'b0, 16'h0003, 8'h00, 8'hA5, 1'b1);
        // RAM write then read back-to-back.
        issue(1'b1, 16'h8001, 8'h5C, 8'h00, 1'b1);
        issue(1'b0, 16'h8001, 8'h00, 8'h5C, 1'b1);
        // ROM write rejected, ROM contents intact.
        issue(1'b1, 16'h0010, 8'hFF, 8'h00, 1'b1);
        issue(1'b0, 16'h0010, 8'h00, 8'h3C, 1'b1);
        idleReq();
        drain();

        // Reset in the middle of a write strobe.
        issue(1'b1, 16'h8002, 8'h77, 8'h00, 1'b0);
        Req_Valid = 1'b0;
        @(negedge CLK);
        check("abort_strobe_low", int'(MemBridge_Load), 0);
        RST = 1'b1;
        @(negedge CLK);
        check("abort_load_high", int'(MemBridge_Load), 1);
        check("abort_dir", int'(MemBridge_Direction), 0);
        check("abort_no_rsp", int'(Rsp_Valid), 0);
        check("abort_ready", int'(Req_Ready), 1);
        RST = 1'b0;
        lastRd = 8'h00;
        repeat (6) @(negedge CLK);
        check("abort_quiet", int'(Rsp_Valid), 0);

        // Random RAM fill and readback.
        rsp0 = rspCount;
        for (int i = 0; i < 5; i++) begin
            rnd[i] = 8'($urandom_range(0, 255));
            issue(1'b1, 16'h8000 + 16'(i), rnd[i], 8'h00, 1'b1);
        end
        for (int i = 0; i < 5; i++)
            issue(1'b0, 16'h8000 + 16'(i), 8'h00, rnd[i], 1'b1);
        idleReq();
        drain();
        check("rsp_count", rspCount - rsp0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case a wait above never resolves.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
